// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and FSM encoding for the data-memory responder
// Purpose: state encoding, default wait-state count and byte-lane geometry used by
//          dmem_if, dmem_array and dmem_responder.
// Ports:   none (package).
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   localparam int DEFAULT_WAIT_CYCLES = 2;
   localparam int LANE_W              = 8;
   localparam int NUM_LANES           = 4;
   localparam int WORD_W              = LANE_W * NUM_LANES;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - initiator/responder data-memory bus
// Purpose: groups the request and completion signals of one data-memory port.
// Ports:   master drives Req/We/Addr/WriteData/ByteEn and observes Ready/ReadData/Err;
//          slave is the mirror image.
interface dmem_if;
   import dmem_pkg::*;

   logic                 Req;
   logic                 We;
   logic [31:0]          Addr;
   logic [WORD_W-1:0]    WriteData;
   logic [NUM_LANES-1:0] ByteEn;
   logic                 Ready;
   logic [WORD_W-1:0]    ReadData;
   logic                 Err;

   modport master (
      output Req, We, Addr, WriteData, ByteEn,
      input  Ready, ReadData, Err
   );

   modport slave (
      input  Req, We, Addr, WriteData, ByteEn,
      output Ready, ReadData, Err
   );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 word storage with byte-enable write
// Purpose: synchronous byte-lane write and synchronous read; contents are never reset.
// Ports:   clk   - clock
//          addr  - word index shared by read and write
//          we/be - write strobe and per-lane enables, wdata - write data
//          re    - read strobe; rdata updates only when re is high and holds otherwise
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic [AW-1:0]        addr,
   input  logic                 we,
   input  logic [NUM_LANES-1:0] be,
   input  logic [WORD_W-1:0]    wdata,
   input  logic                 re,
   output logic [WORD_W-1:0]    rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
               mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder with fault detection
// Purpose: accepts one load/store at a time, inserts WAIT_CYCLES wait states, then
//          pulses Ready for one cycle with ReadData/Err.
// Ports:   CLK    - clock, rising edge
//          ResetN - asynchronous active-low reset
//          bus    - dmem_if slave: Req/We/Addr/WriteData/ByteEn in, Ready/ReadData/Err out
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic  CLK,
   input  logic  ResetN,
   dmem_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t state, state_nxt;
   logic [3:0] cnt;

   logic                 cap_we;
   logic [31:0]          cap_addr;
   logic [WORD_W-1:0]    cap_wdata;
   logic [NUM_LANES-1:0] cap_be;

   logic                 acc_we;
   logic [31:0]          acc_addr;
   logic [WORD_W-1:0]    acc_wdata;
   logic [NUM_LANES-1:0] acc_be;

   logic              fault;
   logic              enter_resp;
   logic              ld_ok;
   logic              st_ok;
   logic              rd_sel;
   logic              err_q;
   logic [WORD_W-1:0] arr_rdata;

   // With no wait states the access happens on the capture edge itself, so the
   // bus inputs are used directly while IDLE; otherwise the captured copy is used.
   always_comb begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_be    = cap_be;
      if (state == IDLE) begin
         acc_we    = bus.We;
         acc_addr  = bus.Addr;
         acc_wdata = bus.WriteData;
         acc_be    = bus.ByteEn;
      end
   end

   assign fault = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != 32'd0);

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Req) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= 32'd0;
         cap_wdata <= '0;
         cap_be    <= '0;
      end else if (state == IDLE && bus.Req) begin
         cnt       <= CNT_INIT;
         cap_we    <= bus.We;
         cap_addr  <= bus.Addr;
         cap_wdata <= bus.WriteData;
         cap_be    <= bus.ByteEn;
      end else if (state == WAIT && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign st_ok = enter_resp &&  acc_we && !fault;
   assign ld_ok = enter_resp && !acc_we && !fault;

   // rd_sel remembers whether the last completed access was a clean load; the array
   // read register only updates on such loads, so ReadData holds between responses.
   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         rd_sel <= 1'b0;
         err_q  <= 1'b0;
      end else if (enter_resp) begin
         rd_sel <= ld_ok;
         err_q  <= fault;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (CLK),
      .addr  (acc_addr[AW+1:2]),
      .we    (st_ok),
      .be    (acc_be),
      .wdata (acc_wdata),
      .re    (ld_ok),
      .rdata (arr_rdata)
   );

   assign bus.Ready    = (state == RESP);
   assign bus.Err      = err_q;
   assign bus.ReadData = rd_sel ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized, model-checked bench for dmem_responder
module tb_dmem_responder;

   localparam int W_MAIN = 2;

   logic CLK = 1'b0;
   logic ResetN;

   always #5 CLK = ~CLK;

   dmem_if bus ();
   dmem_if bus0 ();

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(W_MAIN)) dut (
      .CLK    (CLK),
      .ResetN (ResetN),
      .bus    (bus)
   );

   dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
      .CLK    (CLK),
      .ResetN (ResetN),
      .bus    (bus0)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model (main instance) ----------
   int          ecnt      = 0;
   int          resp_edge = 0;
   bit          busy      = 0;
   bit          in_resp   = 0;
   bit          m_we;
   logic [31:0] m_addr, m_wd;
   logic [3:0]  m_be;
   bit          exp_ready = 0;
   bit          exp_err   = 0;
   logic [31:0] exp_rd    = 32'd0;
   logic [31:0] exp_mask  = 32'hFFFF_FFFF;
   logic [31:0] mem_m [256];
   bit   [3:0]  known [256];

   always @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         busy      = 0;
         in_resp   = 0;
         exp_ready = 0;
         exp_err   = 0;
         exp_rd    = 32'd0;
         exp_mask  = 32'hFFFF_FFFF;
      end else begin
         ecnt++;
         if (in_resp) begin
            in_resp = 0;
            busy    = 0;
         end else if (!busy && bus.Req) begin
            busy      = 1;
            m_we      = bus.We;
            m_addr    = bus.Addr;
            m_wd      = bus.WriteData;
            m_be      = bus.ByteEn;
            resp_edge = ecnt + W_MAIN;
         end
         if (busy && !in_resp && ecnt == resp_edge) begin
            in_resp  = 1;
            exp_mask = 32'hFFFF_FFFF;
            exp_rd   = 32'd0;
            // legal byte range is 0 .. 4*256-1, word aligned
            if (m_addr % 4 != 0 || m_addr >= 32'd1024) begin
               exp_err = 1;
            end else begin
               exp_err = 0;
               if (m_we) begin
                  for (int i = 0; i < 4; i++) begin
                     if (m_be[i]) begin
                        mem_m[m_addr/4][8*i +: 8] = m_wd[8*i +: 8];
                        known[m_addr/4][i] = 1'b1;
                     end
                  end
               end else begin
                  exp_rd = mem_m[m_addr/4];
                  for (int i = 0; i < 4; i++) begin
                     exp_mask[8*i +: 8] = known[m_addr/4][i] ? 8'hFF : 8'h00;
                  end
               end
            end
         end
         exp_ready = in_resp;
      end
   end

   always @(negedge CLK) begin
      if (ResetN === 1'b1) begin
         check("cyc_ready", 32'(bus.Ready), 32'(exp_ready));
         check("cyc_err", 32'(bus.Err), 32'(exp_err));
         check("cyc_rdata", bus.ReadData & exp_mask, exp_rd & exp_mask);
      end
   end

   // ---------------- drivers ----------------
   task automatic set_req(input bit sel, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
      if (sel) begin
         bus0.Req = r; bus0.We = w; bus0.Addr = a; bus0.WriteData = wd; bus0.ByteEn = be;
      end else begin
         bus.Req = r; bus.We = w; bus.Addr = a; bus.WriteData = wd; bus.ByteEn = be;
      end
   endtask

   // lat counts negedges from the cycle in which Req is first sampled (that cycle = 1)
   task automatic access(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input bit drop,
                         output logic [31:0] rd, output logic er, output int lat);
      bit got = 0;
      @(posedge CLK); #1;
      set_req(sel, 1'b1, w, a, wd, be);
      lat = 0; rd = 32'd0; er = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge CLK);
         lat++;
         if (sel ? bus0.Ready : bus.Ready) begin
            got = 1;
            rd  = sel ? bus0.ReadData : bus.ReadData;
            er  = sel ? bus0.Err : bus.Err;
         end
         if (drop && lat == 2) begin
            if (sel) bus0.Req = 1'b0; else bus.Req = 1'b0;
         end
      end
      if (sel) bus0.Req = 1'b0; else bus.Req = 1'b0;
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL access_timeout: actual no Ready required Ready for addr %h", a);
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          pulses;
   int          pos [3];

   initial begin
      ResetN = 1'b0;
      set_req(0, 0, 0, 32'd0, 32'd0, 4'h0);
      set_req(1, 0, 0, 32'd0, 32'd0, 4'h0);
      repeat (2) @(posedge CLK);
      #1;
      check("reset_ready", 32'(bus.Ready), 32'd0);
      check("reset_err", 32'(bus.Err), 32'd0);
      check("reset_rdata", bus.ReadData, 32'd0);
      ResetN = 1'b1;

      // store then load
      access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
      check("store_latency", 32'(lat), 32'd4);
      check("store_rdata", rd, 32'd0);
      check("store_err", 32'(er), 32'd0);
      access(0, 0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
      check("load_rdata", rd, 32'hDEADBEEF);
      check("load_err", 32'(er), 32'd0);

      // single byte lane
      access(0, 1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er, lat);
      access(0, 0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
      check("lane_rdata", rd, 32'hDEADBEAA);

      // empty byte enable
      access(0, 1, 32'h10, 32'h11111111, 4'h0, 0, rd, er, lat);
      check("be0_err", 32'(er), 32'd0);
      access(0, 0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
      check("be0_rdata", rd, 32'hDEADBEAA);

      // faults
      access(0, 1, 32'h0, 32'h01020304, 4'hF, 0, rd, er, lat);
      access(0, 0, 32'h12, 32'd0, 4'h0, 0, rd, er, lat);
      check("misalign_err", 32'(er), 32'd1);
      check("misalign_rdata", rd, 32'd0);
      access(0, 1, 32'h400, 32'h55555555, 4'hF, 0, rd, er, lat);
      check("range_err", 32'(er), 32'd1);
      access(0, 0, 32'h0, 32'd0, 4'h0, 0, rd, er, lat);
      check("range_nowrite", rd, 32'h01020304);

      // Req dropped right after capture
      access(0, 0, 32'h10, 32'd0, 4'h0, 1, rd, er, lat);
      check("drop_latency", 32'(lat), 32'd4);
      check("drop_rdata", rd, 32'hDEADBEAA);
      pulses = 0;
      repeat (6) begin
         @(negedge CLK);
         if (bus.Ready) pulses++;
      end
      check("drop_single_pulse", 32'(pulses), 32'd0);

      // Req held high: back-to-back accesses only one per WAIT_CYCLES+2 cycles
      @(posedge CLK); #1;
      set_req(0, 1, 0, 32'h10, 32'd0, 4'h0);
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLK);
         if (bus.Ready) begin
            if (pulses < 3) pos[pulses] = i;
            pulses++;
         end
      end
      bus.Req = 1'b0;
      check("held_pulses", 32'(pulses), 32'd3);
      check("held_first", 32'(pos[0]), 32'd4);
      check("held_second", 32'(pos[1]), 32'd8);

      // reset during WAIT aborts a store
      access(0, 1, 32'h20, 32'h12345678, 4'hF, 0, rd, er, lat);
      @(posedge CLK); #1;
      set_req(0, 1, 1, 32'h20, 32'h99999999, 4'hF);
      @(posedge CLK); #1;
      bus.Req = 1'b0;
      #1 ResetN = 1'b0;
      #1;
      check("reset_mid_ready", 32'(bus.Ready), 32'd0);
      #1 ResetN = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(negedge CLK);
         if (bus.Ready) pulses++;
      end
      check("abort_no_ready", 32'(pulses), 32'd0);
      access(0, 0, 32'h20, 32'd0, 4'h0, 0, rd, er, lat);
      check("abort_nowrite", rd, 32'h12345678);

      // zero wait states, 16-word instance
      access(1, 1, 32'h4, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
      check("w0_latency", 32'(lat), 32'd2);
      access(1, 0, 32'h4, 32'd0, 4'h0, 0, rd, er, lat);
      check("w0_rdata", rd, 32'hCAFEF00D);
      check("w0_err", 32'(er), 32'd0);
      access(1, 0, 32'h40, 32'd0, 4'h0, 0, rd, er, lat);
      check("w0_range_err", 32'(er), 32'd1);
      check("w0_range_rdata", rd, 32'd0);

      // randomized traffic on the main instance, checked every cycle by the model
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         int          kind;
         a    = 32'($urandom_range(0, 15)) * 4;
         kind = $urandom_range(0, 7);
         if (kind == 0) a = a | 32'($urandom_range(1, 3));
         if (kind == 1) a = a | (32'($urandom_range(1, 32'h3FFFFF)) << 10);
         access(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), rd, er, lat);
         if ($urandom_range(0, 3) == 0) @(posedge CLK);
      end

      repeat (3) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
